// File: rtl/pdm_pkg.sv
// pdm_pkg
// Shared definitions for the PDM decimator: output sample width, the CIC
// register width as a function of the decimation exponent, the settle-guard
// terminal count and the 8-bit output saturation helper.
package pdm_pkg;

    localparam int SAMPLE_W = 8;

    // Ticks that must pass after reset before a sample is flagged valid.
    localparam logic [1:0] SETTLE_DONE = 2'd3;

    // A sinc3 filter with decimation R = 2^d has a DC gain of R^3 = 2^(3d).
    // One extra bit lets the full-scale value 2^(3d) be represented so that
    // it can be detected and saturated.
    function automatic int cic_width(input int decim_log2);
        return 3 * decim_log2 + 1;
    endfunction

    // The scaled comb output is SAMPLE_W+1 bits wide; only full scale sets
    // the top bit, and it clamps to the largest 8-bit code.
    function automatic logic [SAMPLE_W-1:0] sat8(input logic [SAMPLE_W:0] s);
        return s[SAMPLE_W] ? {SAMPLE_W{1'b1}} : s[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/pdm_decimator_comb.sv
// cic_comb_stage
// One differentiator of the decimated half of a CIC filter.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset, clears the delay register
//   en_i   : decimation tick; the delay register only loads on a tick
//   x_i    : stage input (W bits, modulo 2^W)
//   y_o    : x_i minus the input captured on the previous tick
module cic_comb_stage #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [W-1:0] x_i,
    output logic [W-1:0] y_o
);

    logic [W-1:0] z_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= '0;
        end else if (en_i) begin
            z_q <= x_i;
        end
    end

    // Unsigned wrap-around is intended: integrator overflow cancels here.
    assign y_o = x_i - z_q;

endmodule

// File: rtl/pdm_decimator.sv
// pdm_decimator
// Third-order CIC (sinc3) decimator turning a unipolar 1-bit pulse-density
// stream into 8-bit samples, one per R = 2^DECIM_LOG2 input bits.
//   DECIM_LOG2 : log2 of the decimation ratio, legal range 3..8
//   clk        : system clock, one PDM bit consumed per cycle
//   rst_n      : asynchronous active-low reset
//   pdm_in     : pulse-density bit, 1 counts +1, 0 counts 0
//   data_out   : decoded sample, updated on every decimation tick, held between
//   data_valid : one-cycle pulse on the edge that loads data_out, suppressed
//                for the first three ticks after reset while the filter fills
module pdm_decimator
    import pdm_pkg::*;
#(
    parameter int DECIM_LOG2 = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pdm_in,
    output logic [SAMPLE_W-1:0] data_out,
    output logic                data_valid
);

    localparam int W = cic_width(DECIM_LOG2);
    // Dropping SHIFT LSBs of the comb output leaves exactly SAMPLE_W+1 bits.
    localparam int SHIFT = W - (SAMPLE_W + 1);
    localparam logic [DECIM_LOG2-1:0] DCNT_LAST = '1;

    // ---------------------------------------------------------------
    // Integrators, running at the input rate. Overflow wraps freely;
    // the combs remove it as long as all arithmetic is modulo 2^W.
    // ---------------------------------------------------------------
    logic [W-1:0] i1_q, i2_q, i3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1_q <= '0;
            i2_q <= '0;
            i3_q <= '0;
        end else begin
            i1_q <= i1_q + W'(pdm_in);
            i2_q <= i2_q + i1_q;
            i3_q <= i3_q + i2_q;
        end
    end

    // ---------------------------------------------------------------
    // Decimation counter and tick
    // ---------------------------------------------------------------
    logic [DECIM_LOG2-1:0] dcnt_q, dcnt_d;
    logic                  tick;

    assign tick = (dcnt_q == DCNT_LAST);

    // ---------------------------------------------------------------
    // Combs, running at the decimated rate
    // ---------------------------------------------------------------
    logic [W-1:0] y1, y2, y3;

    cic_comb_stage #(.W(W)) u_comb1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (tick),
        .x_i   (i3_q),
        .y_o   (y1)
    );

    cic_comb_stage #(.W(W)) u_comb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (tick),
        .x_i   (y1),
        .y_o   (y2)
    );

    cic_comb_stage #(.W(W)) u_comb3 (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (tick),
        .x_i   (y2),
        .y_o   (y3)
    );

    // The fractional bits below the output LSB are discarded by design.
    logic unused_y3_lsbs;
    assign unused_y3_lsbs = ^y3[SHIFT-1:0];

    // ---------------------------------------------------------------
    // Settle guard and output register
    // ---------------------------------------------------------------
    logic [1:0]          settle_q, settle_d;
    logic [SAMPLE_W-1:0] data_out_q, data_out_d;
    logic                data_valid_q, data_valid_d;

    always_comb begin
        dcnt_d       = dcnt_q + DECIM_LOG2'(1);
        settle_d     = settle_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        if (tick) begin
            if (settle_q != SETTLE_DONE) begin
                settle_d = settle_q + 2'd1;
            end
            // Full scale (all-ones input) lands exactly on 2^SAMPLE_W.
            data_out_d   = sat8(y3[W-1:SHIFT]);
            data_valid_d = (settle_q == SETTLE_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q       <= '0;
            settle_q     <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            dcnt_q       <= dcnt_d;
            settle_q     <= settle_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// tb_pdm_decimator
// Self-checking bench for pdm_decimator (R = 32). Stimulus is either a
// constant bit or a first-order delta-sigma modulator model (the loopback
// DAC). Each frame of R input bits that should end in a valid pulse pushes
// its expected sample range onto exp_q; a negedge monitor pops and compares
// on every data_valid and also checks pulse spacing.
module tb_pdm_decimator;

    localparam int DL = 5;
    localparam int R  = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pdm_in;
    logic [7:0] data_out;
    logic       data_valid;

    pdm_decimator #(.DECIM_LOG2(DL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pdm_in     (pdm_in),
        .data_out   (data_out),
        .data_valid (data_valid)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- scoreboard state ----------------
    typedef struct {
        string      name;
        logic [7:0] lo;
        logic [7:0] hi;
        bit         mono;   // also require >= previous valid sample
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         rel_edge = 0;
    int         last_valid_edge = 0;
    bit         first_after_rst = 1'b0;
    logic [7:0] prev_sample = 8'h00;
    int         frames_since_rst = 0;

    // ---------------- stimulus source state ----------------
    int         mode = 0;        // 0: const 0, 1: const 1, 2: delta-sigma
    logic [7:0] ds_data = 8'h00;
    logic [7:0] ds_acc = 8'h00;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] lo, input logic [31:0] hi);
        checks++;
        if ($isunknown(act) || act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && data_valid !== 1'b0) begin
            if (first_after_rst)
                check("first_valid_edge", edge_cnt - rel_edge, 4 * R, 4 * R);
            else
                check("valid_period", edge_cnt - last_valid_edge, R, R);
            first_after_rst = 1'b0;
            last_valid_edge = edge_cnt;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got data_out=%0d with no sample expected (t=%0t)",
                         data_out, $time);
            end else begin
                e = exp_q.pop_front();
                check(e.name, data_out, e.lo, e.hi);
                if (e.mono) check("step_monotonic", data_out, prev_sample, 8'hFF);
            end
            prev_sample = data_out;
        end
    end

    // ---------------- driver ----------------
    // First-order delta-sigma DAC: the carry of an 8-bit phase accumulator.
    function automatic logic next_bit();
        logic [8:0] sum;
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            default: begin
                sum    = {1'b0, ds_acc} + {1'b0, ds_data};
                ds_acc = sum[7:0];
                return sum[8];
            end
        endcase
    endfunction

    task automatic drive_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            pdm_in = next_bit();
            @(negedge clk);
        end
    endtask

    // One frame = R input bits ending on a tick. Frames 0..2 after reset
    // never produce a valid pulse, so nothing is expected for them.
    task automatic run_frame(input string name, input logic [7:0] lo,
                             input logic [7:0] hi, input bit mono);
        exp_t e;
        if (frames_since_rst >= 3) begin
            e.name = name;
            e.lo   = lo;
            e.hi   = hi;
            e.mono = mono;
            exp_q.push_back(e);
        end
        drive_cycles(R);
        frames_since_rst++;
    endtask

    task automatic release_reset();
        rst_n            = 1'b1;
        rel_edge         = edge_cnt;
        first_after_rst  = 1'b1;
        frames_since_rst = 0;
        ds_acc           = 8'h00;
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pdm_in = i[0];
            @(negedge clk);
        end
        #1;
        check("reset_data_out", data_out, 0, 0);
        check("reset_data_valid", data_valid, 0, 0);
        check("sb_drained", exp_q.size(), 0, 0);
        exp_q.delete();
        @(negedge clk);
        release_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        int         mode;
        logic [7:0] data;
        int         frames;
        logic [7:0] lo;
        logic [7:0] hi;
    } vec_t;

    vec_t vecs[6];

    initial begin
        rst_n  = 1'b0;
        pdm_in = 1'b0;

        vecs[0] = '{"const0",    0, 8'h00, 63,   8'h00, 8'h00};
        // 2200 frames = 70400 cycles: every integrator wraps at least once.
        vecs[1] = '{"const1",    1, 8'h00, 2200, 8'hFF, 8'hFF};
        vecs[2] = '{"loop_0x80", 2, 8'h80, 20,   8'h7F, 8'h81};
        vecs[3] = '{"loop_0x40", 2, 8'h40, 20,   8'h3F, 8'h41};
        vecs[4] = '{"loop_0xC0", 2, 8'hC0, 20,   8'hBF, 8'hC1};
        // At 0xFF the modulator emits one 0 per 256 bits; when that 0 sits at
        // the sinc3 peak (weight 768 of 32768) the sample dips to 250.
        vecs[5] = '{"loop_0xFF", 2, 8'hFF, 20,   8'hFA, 8'hFF};

        for (int v = 0; v < 6; v++) begin
            apply_reset();
            mode    = vecs[v].mode;
            ds_data = vecs[v].data;
            for (int f = 0; f < vecs[v].frames; f++)
                run_frame(vecs[v].name, vecs[v].lo, vecs[v].hi, 1'b0);
        end

        // Step 0x40 -> 0xC0 in loopback: three pulses of rising transient,
        // the third already settled, then steady state.
        apply_reset();
        mode    = 2;
        ds_data = 8'h40;
        for (int f = 0; f < 8; f++) run_frame("step_pre", 8'h3F, 8'h41, 1'b0);
        ds_data = 8'h40 + 8'h80;
        run_frame("step_t1", 8'h3F, 8'hC1, 1'b1);
        run_frame("step_t2", 8'h3F, 8'hC1, 1'b1);
        run_frame("step_t3", 8'hBF, 8'hC1, 1'b1);
        for (int f = 0; f < 5; f++) run_frame("step_post", 8'hBF, 8'hC1, 1'b0);

        // Mid-frame reset: outputs must clear without a clock edge and the
        // settle guard must restart from zero.
        apply_reset();
        mode = 1;
        for (int f = 0; f < 5; f++) run_frame("pre_mid_rst", 8'hFF, 8'hFF, 1'b0);
        drive_cycles(17);
        check("pre_mid_rst_data_out", data_out, 8'hFF, 8'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_data_out", data_out, 0, 0);
        check("async_rst_data_valid", data_valid, 0, 0);
        check("mid_rst_sb_drained", exp_q.size(), 0, 0);
        exp_q.delete();
        @(negedge clk);
        release_reset();
        for (int f = 0; f < 6; f++) run_frame("post_mid_rst", 8'hFF, 8'hFF, 1'b0);

        @(negedge clk);
        #1;
        check("sb_drained_end", exp_q.size(), 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
